sfp_acc_buffer: RTL and testbench

//  Next-gen special function processor for the corelet. Sits after the OFIFO and takes COL-lane

---
 rtl/sfp_acc_buffer.sv | 199 +++++++++++++++++++
 tb/tb_sfp_acc_buffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_acc_buffer.sv
// -----------------------------------------------------------------------------
// sfp_acc_buffer
//   Special function processor stage behind the OFIFO. Each accepted COL-lane
//   psum vector is merged into one DEPTH-entry accumulation buffer (load,
//   saturating add or signed max) or sent straight to the output (bypass).
//   A drain FSM streams every buffer entry, in order, through a valid/ready
//   output register, optionally clearing entries as they leave, and reports
//   per-lane saturation through sticky flags.
//
//   Optional feature macro: SFP_RELU_EN
//     defined   : drained lanes whose sign bit is set are output as 0
//                 (buffer contents and bypass data are not affected)
//     undefined : drained lanes are output raw; no ReLU logic is built
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready never depends on in_valid)
//   in_psum            COL lanes, lane i = [PSUM_BW*(i+1)-1 : PSUM_BW*i]
//   in_addr, in_mode   target entry; 00 load, 01 sat-acc, 10 max, 11 bypass
//   drain_i            full-buffer drain request, level-sampled in IDLE
//   out_valid/out_ready/out_data  registered output stream
//   drain_done         one-cycle pulse after the final drain handshake
//   ovf_flag           sticky per-lane saturation flags, cleared on drain entry
// -----------------------------------------------------------------------------
module sfp_acc_buffer #(
  parameter int PSUM_BW        = 16,
  parameter int COL            = 8,
  parameter int DEPTH          = 16,
  parameter bit CLEAR_ON_DRAIN = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PSUM_BW*COL-1:0]     in_psum,
  input  logic [$clog2(DEPTH)-1:0]   in_addr,
  input  logic [1:0]                 in_mode,
  input  logic                       drain_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PSUM_BW*COL-1:0]     out_data,
  output logic                       drain_done,
  output logic [COL-1:0]             ovf_flag
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {MODE_LOAD = 2'b00, MODE_ACC = 2'b01,
                            MODE_MAX = 2'b10, MODE_BYP = 2'b11} mode_e;
  typedef enum logic {IDLE, DRAIN} state_e;
  typedef logic [COL-1:0][PSUM_BW-1:0] vec_t;

  // Returns {clamped, value}: the sum is formed one bit wider so a sign
  // disagreement between the top two bits exposes the overflow direction.
  function automatic logic [PSUM_BW:0] sat_add(input logic [PSUM_BW-1:0] a,
                                               input logic [PSUM_BW-1:0] b);
    logic [PSUM_BW:0] s;
    s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
    if (s[PSUM_BW] != s[PSUM_BW-1])
      return {1'b1, s[PSUM_BW], {(PSUM_BW-1){~s[PSUM_BW]}}};
    return {1'b0, s[PSUM_BW-1:0]};
  endfunction

  state_e           state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;          // next entry to load into the output
  vec_t             buf_q [DEPTH];
  vec_t             buf_d [DEPTH];
  logic             out_valid_q, out_valid_d;
  vec_t             out_data_q, out_data_d;
  logic             out_drain_q, out_drain_d;  // output holds a drained entry
  logic [AW-1:0]    out_idx_q, out_idx_d;      // which entry, for clear/last
  logic             drain_done_q, drain_done_d;
  logic [COL-1:0]   ovf_q, ovf_d;

  vec_t             in_vec, cur_vec, wr_vec, drain_vec;
  logic [COL-1:0]   wr_ovf;
  logic             accept, out_hs, out_free, addr_ok;

  assign in_vec   = in_psum;
  assign out_hs   = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = (state_q == IDLE) & out_free;
  assign accept   = in_valid & in_ready;
  assign addr_ok  = ({1'b0, in_addr} < DEPTH_W);

  // Merge of the incoming vector with the addressed entry.
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_vec = buf_q[in_addr];
    wr_vec  = cur_vec;
    wr_ovf  = '0;
    for (int i = 0; i < COL; i++) begin
      case (mode_e'(in_mode))
        MODE_LOAD: wr_vec[i] = in_vec[i];
        MODE_ACC:  {wr_ovf[i], wr_vec[i]} = sat_add(cur_vec[i], in_vec[i]);
        MODE_MAX:  if ($signed(in_vec[i]) > $signed(cur_vec[i])) wr_vec[i] = in_vec[i];
        default:   ;
      endcase
    end
  end

  // Entry presented to the output during drain, after the optional filter.
  always_comb begin
    drain_vec = buf_q[cnt_q[AW-1:0]];
`ifdef SFP_RELU_EN
    for (int i = 0; i < COL; i++)
      if (drain_vec[i][PSUM_BW-1]) drain_vec[i] = '0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_drain_d  = out_drain_q;
    out_idx_d    = out_idx_q;
    drain_done_d = 1'b0;
    ovf_d        = ovf_q;

    if (out_hs) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mode_e'(in_mode) == MODE_BYP) begin
            out_valid_d = 1'b1;
            out_data_d  = in_vec;
            out_drain_d = 1'b0;
          end else if (addr_ok) begin
            buf_d[in_addr] = wr_vec;
            ovf_d          = ovf_q | wr_ovf;
          end
        end
        if (drain_i) begin
          state_d = DRAIN;
          cnt_d   = '0;
          ovf_d   = '0;
        end
      end
      DRAIN: begin
        if (out_hs && out_drain_q) begin
          if (CLEAR_ON_DRAIN) buf_d[out_idx_q] = '0;
          if (out_idx_q == LAST_IDX) begin
            state_d      = IDLE;
            drain_done_d = 1'b1;
          end
        end
        // Refill whenever the output register is empty or emptying this cycle.
        if ((cnt_q < DEPTH_W) && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = drain_vec;
          out_drain_d = 1'b1;
          out_idx_d   = cnt_q[AW-1:0];
          cnt_d       = cnt_q + (AW+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the buffer sits in the reset domain because the design must read
  // back all zeros after reset; it is small enough to be built from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      buf_q        <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_drain_q  <= 1'b0;
      out_idx_q    <= '0;
      drain_done_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_drain_q  <= out_drain_d;
      out_idx_q    <= out_idx_d;
      drain_done_q <= drain_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign drain_done = drain_done_q;
  assign ovf_flag   = ovf_q;

endmodule

// File: tb/tb_sfp_acc_buffer.sv
// -----------------------------------------------------------------------------
// tb_sfp_acc_buffer
//   Directed stimulus for sfp_acc_buffer with hand-computed expectations.
//   Expected output vectors are queued as stimulus is issued; a monitor pops
//   and compares them on every output handshake.
// -----------------------------------------------------------------------------
module tb_sfp_acc_buffer;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] MAX  = 2'b10;
  localparam logic [1:0] BYP  = 2'b11;

  typedef logic [COL-1:0][PSUM_BW-1:0] vec_t;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [PSUM_BW*COL-1:0] in_psum;
  logic [AW-1:0]          in_addr;
  logic [1:0]             in_mode;
  logic                   drain_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [PSUM_BW*COL-1:0] out_data;
  logic                   drain_done;
  logic [COL-1:0]         ovf_flag;

  sfp_acc_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_psum   (in_psum),
    .in_addr   (in_addr),
    .in_mode   (in_mode),
    .drain_i   (drain_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drain_done(drain_done),
    .ovf_flag  (ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   hs_cnt   = 0;
  vec_t sb[$];
  vec_t exp_mem [DEPTH];
  vec_t mon_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every output handshake consumes one expected vector.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", out_data);
      end else begin
        mon_exp = sb.pop_front();
        check("out_data", out_data, mon_exp);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t lane(input int i, input logic [15:0] val);
    vec_t v;
    v    = '0;
    v[i] = val;
    return v;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    foreach (exp_mem[k]) exp_mem[k] = '0;
  endtask

  // Presents one vector and holds it until accepted (bounded).
  task automatic send(input logic [AW-1:0] a, input logic [1:0] m, input vec_t v,
                      input logic with_drain);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_addr  = a;
    in_mode  = m;
    in_psum  = v;
    drain_i  = with_drain;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      sync();
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    in_valid = 1'b0;
    drain_i  = 1'b0;
  endtask

  // Expects exp_mem[0..DEPTH-1] in order. issue=0 means DRAIN was already
  // entered by the caller on the previous edge.
  task automatic do_drain(input bit issue, input bit bp);
    int start;
    bit seen;
    for (int k = 0; k < DEPTH; k++) sb.push_back(exp_mem[k]);
    start = hs_cnt;
    if (issue) begin
      drain_i = 1'b1;
      sync();
    end
    // drain_i stays high through the first DRAIN cycle; it must be ignored.
    @(negedge clk);
    check("drain_in_ready", in_ready, 0);
    check("drain_ovf_clear", ovf_flag, 0);
    check("drain_first_empty", out_valid, 0);
    sync();
    drain_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      out_ready = bp ? c[0] : 1'b1;
      @(negedge clk);
      if (drain_done) seen = 1'b1;
      else sync();
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=no_done expected=drain_done");
    end
    check("done_out_valid", out_valid, 0);
    check("done_in_ready", in_ready, 1);
    check("drain_handshakes", 128'(hs_cnt - start), 128'(DEPTH));
    check("sb_empty", 128'(sb.size()), 0);
    sb.delete();
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    check("done_pulse_width", drain_done, 0);
    sync();
  endtask

  initial begin
    vec_t v;
    vec_t bv;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_psum   = '0;
    in_addr   = '0;
    in_mode   = LOAD;
    drain_i   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drain_done", drain_done, 0);
    check("rst_ovf", ovf_flag, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    sync();

    // 1: reset mid-stream clears output, flags and buffer.
    send(0, LOAD, lane(1, 16'd32000), 1'b0);
    send(0, ACC,  lane(1, 16'd1000),  1'b0);
    out_ready = 1'b0;
    send(0, BYP, lane(0, 16'hAAAA), 1'b0);
    @(negedge clk);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_ovf", ovf_flag, 8'h02);
    #1 reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_ovf", ovf_flag, 0);
    check("async_rst_out_data", out_data, 0);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    sync();
    zero_exp();
    do_drain(1'b1, 1'b0);

    // 2: back-to-back accumulate on one address.
    send(3, ACC, lane(0, 16'd5),    1'b0);
    send(3, ACC, lane(0, 16'hFFFE), 1'b0);
    send(3, ACC, lane(0, 16'd7),    1'b0);
    zero_exp();
    exp_mem[3] = lane(0, 16'd10);
    do_drain(1'b1, 1'b0);

    // 3: saturation at both rails, sticky flags.
    send(0, LOAD, lane(1, 16'd32000), 1'b0);
    send(0, ACC,  lane(1, 16'd1000),  1'b0);
    @(negedge clk);
    check("sat_pos_ovf", ovf_flag, 8'h02);
    sync();
    v    = '0;
    v[1] = 16'h8000;
    v[2] = 16'h8000;
    send(0, ACC, v, 1'b0);
    @(negedge clk);
    check("sat_mid_ovf", ovf_flag, 8'h02);
    sync();
    send(0, ACC, v, 1'b0);
    repeat (3) sync();
    @(negedge clk);
    check("sat_neg_ovf_sticky", ovf_flag, 8'h06);
    sync();
    zero_exp();
    exp_mem[0] = v;
    do_drain(1'b1, 1'b0);

    // 4: signed max, then bypass under backpressure.
    v    = '0;
    v[0] = 16'hFFFC;
    v[3] = 16'd3;
    send(5, LOAD, v, 1'b0);
    v[0] = 16'd9;
    v[3] = 16'hFFFB;
    send(5, MAX, v, 1'b0);
    send(5, MAX, lane(0, 16'd2), 1'b0);
    bv    = '0;
    bv[0] = 16'h0123;
    bv[7] = 16'hFEDC;
    out_ready = 1'b0;
    sb.push_back(bv);
    send(0, BYP, bv, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("byp_valid_held", out_valid, 1);
      check("byp_data_stable", out_data, bv);
      check("byp_in_ready_low", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    check("byp_release_in_ready", in_ready, 1);
    sync();
    @(negedge clk);
    check("byp_out_cleared", out_valid, 0);
    sync();
    zero_exp();
    v    = '0;
    v[0] = 16'd9;
    v[3] = 16'd3;
    exp_mem[5] = v;
    do_drain(1'b1, 1'b0);

    // 5: full buffer drained under toggling backpressure, then cleared.
    for (int k = 0; k < DEPTH; k++) begin
      v    = '0;
      v[0] = 16'(k + 1);
      v[7] = 16'(k * 256);
      exp_mem[k] = v;
      send(AW'(k), LOAD, v, 1'b0);
    end
    do_drain(1'b1, 1'b1);
    zero_exp();
    do_drain(1'b1, 1'b1);

    // 6: write accepted with the drain request; negative lane filtering.
    v    = '0;
    v[0] = 16'hFFF9;
    v[1] = 16'd7;
    send(0, LOAD, v, 1'b1);
    zero_exp();
`ifdef SFP_RELU_EN
    exp_mem[0] = lane(1, 16'd7);
`else
    exp_mem[0] = v;
`endif
    do_drain(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
